gf2m_xor_acc: RTL

//  Parametrised, digit-serial GF(2^m) adder/accumulator for the ECC datapath. Computes
//  A^B, or folds A into an internal accumulator (acc ^= A), DIGIT bits per cycle to cut

---
 rtl/gf2m_pkg.sv | 25 ++
 rtl/gf2m_xor_acc_if.sv | 26 ++
 rtl/gf2m_digit_xor.sv | 15 +
 rtl/gf2m_xor_acc.sv | 124 ++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// rtl/gf2m_pkg.sv - shared encodings and defaults for the GF(2^m) XOR accumulator
package gf2m_pkg;

  localparam int GF_WIDTH_DEFAULT = 136;
  localparam int GF_DIGIT_DEFAULT = 34;

  typedef enum logic [1:0] {
    GF_ADD  = 2'b00,
    GF_ACC  = 2'b01,
    GF_LOAD = 2'b10,
    GF_CLR  = 2'b11
  } gf_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } gf_state_e;

  // Digit counter width; a single-digit operation still keeps a 1-bit counter.
  function automatic int gf_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/gf2m_xor_acc_if.sv
// rtl/gf2m_xor_acc_if.sv - command/result handshake bundle for gf2m_xor_acc
interface gf2m_xor_acc_if import gf2m_pkg::*; #(
  parameter int WIDTH = GF_WIDTH_DEFAULT
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             busy;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, c, busy
  );

endinterface

// File: rtl/gf2m_digit_xor.sv
// rtl/gf2m_digit_xor.sv - one DIGIT-wide GF(2) addition slice
module gf2m_digit_xor #(
  parameter int DIGIT = 34
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic [DIGIT-1:0] acc_i,
  input  logic             sel_i,
  output logic [DIGIT-1:0] y_o
);

  // sel_i picks the accumulator as second operand (ACC), otherwise operand B (ADD).
  assign y_o = a_i ^ (sel_i ? acc_i : b_i);

endmodule

// File: rtl/gf2m_xor_acc.sv
// rtl/gf2m_xor_acc.sv - digit-serial GF(2^m) adder / accumulator with valid/ready handshakes
module gf2m_xor_acc import gf2m_pkg::*; #(
  parameter int WIDTH = GF_WIDTH_DEFAULT,
  parameter int DIGIT = GF_DIGIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  gf2m_xor_acc_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = gf_cnt_w(NDIG);

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("gf2m_xor_acc: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  // Words are viewed as NDIG digits so the RUN loop can index a digit directly.
  typedef logic [NDIG-1:0][DIGIT-1:0] word_t;

  gf_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  gf_mode_e        mode_q, mode_d;
  word_t           a_q, a_d;
  word_t           b_q, b_d;
  word_t           acc_q, acc_d;
  word_t           c_q, c_d;
  logic [DIGIT-1:0] dig_y;
  logic            last_dig;

  assign last_dig = (cnt_q == CW'(NDIG - 1));

  gf2m_digit_xor #(.DIGIT(DIGIT)) u_digit_xor (
    .a_i   (a_q[cnt_q]),
    .b_i   (b_q[cnt_q]),
    .acc_i (acc_q[cnt_q]),
    .sel_i (mode_q == GF_ACC),
    .y_o   (dig_y)
  );

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= GF_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

  // Next-state logic: accept in IDLE, one digit per RUN edge, hold result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mode_d = gf_mode_e'(bus.mode);
          a_d    = bus.a;
          b_d    = bus.b;
          cnt_d  = '0;
          case (gf_mode_e'(bus.mode))
            GF_ADD, GF_ACC: state_d = S_RUN;
            GF_LOAD: begin
              acc_d   = bus.a;
              c_d     = bus.a;
              state_d = S_DONE;
            end
            default: begin
              acc_d   = '0;
              c_d     = '0;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_RUN: begin
        c_d[cnt_q] = dig_y;
        if (mode_q == GF_ACC) begin
          acc_d[cnt_q] = dig_y;
        end
        if (last_dig) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.c         = c_q;

endmodule
